// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell codes, result codes and controller states
package ttt_pkg;

    // Cell codes; the player codes double as turn values.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    // Result codes
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/pos_decode.sv
// rtl/pos_decode.sv - maps a 1..9 square number to a one-hot cell select
// Ports: move_pos (square 1..9, row-major) -> onehot (bit i = square i+1),
//        out_of_range (high for 0 and 10..15, onehot is then zero).
module pos_decode
    import ttt_pkg::*;
(
    input  logic [3:0] move_pos,
    output logic [8:0] onehot,
    output logic       out_of_range
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < 9; i++) begin
            onehot[i] = (move_pos == 4'(i + 1));
        end
        out_of_range = ~|onehot;
    end

endmodule

// File: rtl/board_ctrl.sv
// rtl/board_ctrl.sv - tic-tac-toe board controller (PLAY/CHECK/OVER)
// Ports: clk, rst (async, active-high); new_game, move_valid/move_pos, undo in;
//        winner/who_win from the external win detector fed by pos1..pos9;
//        pos1..pos9, turn, move_ready, move_accept/move_reject pulses,
//        game_over, result, move_count out.
// Optional macro BOARD_CTRL_UNDO_EN adds one-level undo of the last move.
module board_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       undo,
    input  logic       winner,
    input  logic [1:0] who_win,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic       move_ready,
    output logic       move_accept,
    output logic       move_reject,
    output logic       game_over,
    output logic [1:0] result,
    output logic [3:0] move_count
);

    state_t          state_q, state_n;
    logic [8:0][1:0] board_q, board_n;
    logic [1:0]      turn_q, turn_n;
    logic [1:0]      result_q, result_n;
    logic [3:0]      count_q, count_n;
    logic            accept_q, accept_n;
    logic            reject_q, reject_n;

    logic [8:0]      target_oh;
    logic            target_oor;
    logic            target_busy;
    logic            play_req;
    logic            move_hit;
    logic            undo_hit;
    logic [8:0]      undo_mask;

    pos_decode u_pos_decode (
        .move_pos     (move_pos),
        .onehot       (target_oh),
        .out_of_range (target_oor)
    );

    always_comb begin
        target_busy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (target_oh[i] && (board_q[i] != EMPTY)) target_busy = 1'b1;
        end
    end

    // A move request only counts in PLAY and loses to new_game and to undo.
    assign play_req = (state_q == PLAY) && !new_game && !undo_hit && move_valid;
    assign move_hit = play_req && !target_oor && !target_busy;

`ifdef BOARD_CTRL_UNDO_EN
    logic [8:0] last_q, last_n;
    logic       last_valid_q, last_valid_n;

    assign undo_hit  = undo && last_valid_q && (state_q == PLAY) && !new_game;
    assign undo_mask = last_q;

    always_comb begin
        last_n       = last_q;
        last_valid_n = last_valid_q;
        if (new_game || undo_hit) begin
            last_valid_n = 1'b0;
        end else if (move_hit) begin
            last_n       = target_oh;
            last_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_q       <= last_n;
            last_valid_q <= last_valid_n;
        end
    end
`else
    logic unused_undo;
    assign unused_undo = undo;
    assign undo_hit    = 1'b0;
    assign undo_mask   = '0;
`endif

    always_comb begin
        state_n  = state_q;
        board_n  = board_q;
        turn_n   = turn_q;
        result_n = result_q;
        count_n  = count_q;
        accept_n = 1'b0;
        reject_n = 1'b0;
        if (new_game) begin
            board_n  = '0;
            turn_n   = FIRST_PLAYER;
            result_n = RES_NONE;
            count_n  = '0;
            state_n  = PLAY;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (undo_hit) begin
                        // Turn was toggled by the CHECK after the undone move.
                        for (int i = 0; i < 9; i++) begin
                            if (undo_mask[i]) board_n[i] = EMPTY;
                        end
                        count_n = count_q - 4'd1;
                        turn_n  = other_player(turn_q);
                    end else if (move_hit) begin
                        for (int i = 0; i < 9; i++) begin
                            if (target_oh[i]) board_n[i] = turn_q;
                        end
                        count_n  = count_q + 4'd1;
                        accept_n = 1'b1;
                        state_n  = CHECK;
                    end else if (play_req) begin
                        reject_n = 1'b1;
                    end
                end
                // The detector now sees the board including the new move.
                CHECK: begin
                    if (winner) begin
                        result_n = who_win;
                        state_n  = OVER;
                    end else if (count_q == 4'd9) begin
                        result_n = RES_DRAW;
                        state_n  = OVER;
                    end else begin
                        turn_n  = other_player(turn_q);
                        state_n = PLAY;
                    end
                end
                OVER: begin
                    state_n = OVER;
                end
                default: begin
                    state_n = PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PLAY;
            board_q  <= '0;
            turn_q   <= FIRST_PLAYER;
            result_q <= RES_NONE;
            count_q  <= '0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            board_q  <= board_n;
            turn_q   <= turn_n;
            result_q <= result_n;
            count_q  <= count_n;
            accept_q <= accept_n;
            reject_q <= reject_n;
        end
    end

    assign pos1        = board_q[0];
    assign pos2        = board_q[1];
    assign pos3        = board_q[2];
    assign pos4        = board_q[3];
    assign pos5        = board_q[4];
    assign pos6        = board_q[5];
    assign pos7        = board_q[6];
    assign pos8        = board_q[7];
    assign pos9        = board_q[8];
    assign turn        = turn_q;
    assign move_ready  = (state_q == PLAY);
    assign move_accept = accept_q;
    assign move_reject = reject_q;
    assign game_over   = (state_q == OVER);
    assign result      = result_q;
    assign move_count  = count_q;

endmodule
